// File: rtl/ir_rx_pkg.sv
// Shared types and constants for the IR command receiver: FSM states, burst
// classes, frame field indices, register map and default timing thresholds.
package ir_rx_pkg;

  typedef enum logic [1:0] {IDLE, PULSE, GAP, COMMIT} state_t;
  typedef enum logic [1:0] {GLITCH, SHORT, LONG, START} cls_t;

  localparam logic [2:0] F_START      = 3'd0;
  localparam logic [2:0] F_SELECT     = 3'd1;
  localparam logic [2:0] F_DATA_FIRST = 3'd2;
  localparam logic [2:0] F_DATA_LAST  = 3'd5;

  localparam logic [7:0] DATA_OFS = 8'd0;
  localparam logic [7:0] STAT_OFS = 8'd1;

  localparam int ST_VALID     = 0;
  localparam int ST_OVERRUN   = 1;
  localparam int ST_FRAME_ERR = 2;

  localparam int WIDTH_W = 9;

  localparam int DEF_TICK_CYCLES = 1000;
  localparam int DEF_START_MIN   = 180;
  localparam int DEF_LONG_MIN    = 90;
  localparam int DEF_SHORT_MIN   = 30;
  localparam int DEF_GAP_TIMEOUT = 300;
  localparam int DEF_FILTER_LEN  = 4;

endpackage

// File: rtl/ir_rx_input_sync.sv
// IR envelope conditioning: 2-FF synchronizer, optional majority-free glitch
// filter (IR_RX_GLITCH_FILTER_EN) and rise/fall detection on the clean level.
module ir_rx_input_sync
`ifdef IR_RX_GLITCH_FILTER_EN
  #(parameter int FILTER_LEN = 4)
`endif
(
  input  logic clk,
  input  logic rst,
  input  logic ir_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic ir_p0, ir_p1;
  logic lvl, lvl_q;

  // Stage p0/p1: metastability synchronizer
  always_ff @(posedge clk) begin
    if (rst) begin
      ir_p0 <= 1'b0;
      ir_p1 <= 1'b0;
    end else begin
      ir_p0 <= ir_in;
      ir_p1 <= ir_p0;
    end
  end

`ifdef IR_RX_GLITCH_FILTER_EN
  logic [FILTER_LEN-1:0] hist_p2;
  logic                  filt_p2;

  // Stage p2: level only moves once the whole history window agrees
  always_ff @(posedge clk) begin
    if (rst) begin
      hist_p2 <= '0;
      filt_p2 <= 1'b0;
    end else begin
      hist_p2 <= {hist_p2[FILTER_LEN-2:0], ir_p1};
      if (&hist_p2)
        filt_p2 <= 1'b1;
      else if (~|hist_p2)
        filt_p2 <= 1'b0;
    end
  end

  assign lvl = filt_p2;
`else
  assign lvl = ir_p1;
`endif

  always_ff @(posedge clk) begin
    if (rst) lvl_q <= 1'b0;
    else     lvl_q <= lvl;
  end

  assign level = lvl;
  assign rise  = lvl & ~lvl_q;
  assign fall  = ~lvl & lvl_q;

endmodule

// File: rtl/ir_rx_peripheral.sv
// Bus-mapped IR frame receiver: measures burst/gap widths in ticks, decodes
// START/SELECT/4 data bursts into a byte. Optional IR_RX_GLITCH_FILTER_EN.
module ir_rx_peripheral
  import ir_rx_pkg::*;
#(
  parameter logic [7:0] BASE_ADDR   = 8'hA0,
  parameter int         TICK_CYCLES = DEF_TICK_CYCLES,
  parameter int         START_MIN   = DEF_START_MIN,
  parameter int         LONG_MIN    = DEF_LONG_MIN,
  parameter int         SHORT_MIN   = DEF_SHORT_MIN,
  parameter int         GAP_TIMEOUT = DEF_GAP_TIMEOUT
`ifdef IR_RX_GLITCH_FILTER_EN
  , parameter int       FILTER_LEN  = DEF_FILTER_LEN
`endif
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       IR_IN,
  input  logic [7:0] BUS_ADDR,
  inout  wire  [7:0] BUS_DATA,
  input  logic       BUS_WE,
  output logic       BUS_INTERRUPT_RAISE,
  input  logic       BUS_INTERRUPT_ACK
);

  localparam int                 PRE_W     = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PRE_W-1:0]   PRE_LAST  = PRE_W'(TICK_CYCLES - 1);
  localparam logic [WIDTH_W-1:0] WIDTH_MAX = '1;
  localparam logic [7:0]         DATA_ADDR = BASE_ADDR + DATA_OFS;
  localparam logic [7:0]         STAT_ADDR = BASE_ADDR + STAT_OFS;

  function automatic logic [WIDTH_W-1:0] sat_inc(input logic [WIDTH_W-1:0] w);
    return (w == WIDTH_MAX) ? w : w + 1'b1;
  endfunction

  function automatic cls_t classify(input logic [WIDTH_W-1:0] w);
    if (w >= WIDTH_W'(START_MIN))      return START;
    else if (w >= WIDTH_W'(LONG_MIN))  return LONG;
    else if (w >= WIDTH_W'(SHORT_MIN)) return SHORT;
    else                               return GLITCH;
  endfunction

  logic level, rise, fall, tick;
  logic [PRE_W-1:0]   presc;
  logic [WIDTH_W-1:0] width;
  state_t     state, state_nxt;
  logic [2:0] fld, fld_nxt;
  logic [3:0] bits;
  logic       shift, bit_val, bits_clr, err_set, commit;
  cls_t       cls;
  logic [7:0] stat, stat_nxt, rx_data, bus_out;
  logic       bus_oe, rd_hit, data_rd, stat_wr;

  ir_rx_input_sync
`ifdef IR_RX_GLITCH_FILTER_EN
    #(.FILTER_LEN(FILTER_LEN))
`endif
  u_sync (
    .clk  (CLK),
    .rst  (RESET),
    .ir_in(IR_IN),
    .level(level),
    .rise (rise),
    .fall (fall)
  );

  // Stage: tick prescaler and burst/gap width measurement, both restart on edges
  assign tick = (presc == PRE_LAST);

  always_ff @(posedge CLK) begin
    if (RESET) begin
      presc <= '0;
      width <= '0;
    end else if (rise || fall) begin
      presc <= '0;
      width <= '0;
    end else begin
      presc <= tick ? '0 : presc + 1'b1;
      if (tick) width <= sat_inc(width);
    end
  end

  always_comb begin
    state_nxt = state;
    fld_nxt   = fld;
    shift     = 1'b0;
    bit_val   = 1'b0;
    bits_clr  = 1'b0;
    err_set   = 1'b0;
    commit    = 1'b0;
    cls       = classify(width);
    unique case (state)
      IDLE: if (rise) begin
        state_nxt = PULSE;
        fld_nxt   = F_START;
      end
      PULSE: if (fall) begin
        if (cls == GLITCH) begin
          state_nxt = IDLE;
          err_set   = (fld != F_START);
        end else if (cls == START) begin
          // A START anywhere re-synchronises the frame
          state_nxt = GAP;
          fld_nxt   = F_SELECT;
          bits_clr  = 1'b1;
        end else if (fld == F_START) begin
          state_nxt = IDLE;
        end else begin
          shift   = (fld >= F_DATA_FIRST);
          bit_val = (cls == LONG);
          if (fld == F_DATA_LAST) begin
            state_nxt = COMMIT;
          end else begin
            state_nxt = GAP;
            fld_nxt   = fld + 3'd1;
          end
        end
      end else if (level && width == WIDTH_MAX) begin
        state_nxt = IDLE;
        err_set   = 1'b1;
      end
      GAP: if (rise) begin
        state_nxt = PULSE;
      end else if (width > WIDTH_W'(GAP_TIMEOUT)) begin
        state_nxt = IDLE;
        err_set   = 1'b1;
      end
      COMMIT: begin
        state_nxt = IDLE;
        commit    = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rd_hit  = !BUS_WE && (BUS_ADDR == DATA_ADDR || BUS_ADDR == STAT_ADDR);
  assign data_rd = !BUS_WE && (BUS_ADDR == DATA_ADDR);
  assign stat_wr = BUS_WE && (BUS_ADDR == STAT_ADDR);

  // Hardware set events win over software clears in the same cycle
  always_comb begin
    stat_nxt = stat;
    if (stat_wr) stat_nxt = stat_nxt & ~BUS_DATA;
    if (data_rd) stat_nxt[ST_VALID] = 1'b0;
    if (err_set) stat_nxt[ST_FRAME_ERR] = 1'b1;
    if (commit) begin
      if (stat[ST_VALID] && !data_rd) stat_nxt[ST_OVERRUN] = 1'b1;
      stat_nxt[ST_VALID] = 1'b1;
    end
    stat_nxt[7:3] = 5'd0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state               <= IDLE;
      fld                 <= F_START;
      stat                <= '0;
      rx_data             <= '0;
      BUS_INTERRUPT_RAISE <= 1'b0;
      bus_oe              <= 1'b0;
    end else begin
      state               <= state_nxt;
      fld                 <= fld_nxt;
      stat                <= stat_nxt;
      if (commit) rx_data <= {4'b0, bits};
      BUS_INTERRUPT_RAISE <= commit | (BUS_INTERRUPT_RAISE & ~BUS_INTERRUPT_ACK);
      bus_oe              <= rd_hit;
    end
  end

  always_ff @(posedge CLK) begin
    if (bits_clr)   bits <= '0;
    else if (shift) bits <= {bits[2:0], bit_val};
    if (rd_hit) bus_out <= (BUS_ADDR == STAT_ADDR) ? stat : rx_data;
  end

  assign BUS_DATA = bus_oe ? bus_out : 8'bz;

endmodule

// File: tb/tb_ir_rx_peripheral.sv
// Scoreboard bench for ir_rx_peripheral: directed IR frames and bus accesses
// push expected values; a negedge monitor pops and compares DUT responses.
module tb_ir_rx_peripheral;

  localparam int         TC   = 10;
  localparam logic [7:0] BASE = 8'hA0;
  localparam logic [7:0] STAT = 8'hA1;

  logic       clk = 1'b0;
  logic       rst, ir, we, ack, tb_drv;
  logic [7:0] addr, wdata;
  wire  [7:0] bus_data;
  logic       raise;

  assign bus_data = tb_drv ? wdata : 8'bz;

  always #5 clk = ~clk;

  ir_rx_peripheral #(.TICK_CYCLES(TC)) dut (
    .CLK                (clk),
    .RESET              (rst),
    .IR_IN              (ir),
    .BUS_ADDR           (addr),
    .BUS_DATA           (bus_data),
    .BUS_WE             (we),
    .BUS_INTERRUPT_RAISE(raise),
    .BUS_INTERRUPT_ACK  (ack)
  );

  typedef struct {
    string      name;
    logic [7:0] exp;
    bit         is_irq;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_bad = 0;
  logic rd_req = 1'b0, rd_d = 1'b0, irq_probe = 1'b0;

  always @(posedge clk) rd_d <= rd_req;

  initial begin : monitor
    exp_t       e;
    logic [7:0] act;
    forever begin
      @(negedge clk);
      if (rd_d || irq_probe) begin
        n_vec++;
        if (sb_q.size() == 0) begin
          n_bad++;
          $display("FAIL sb_empty: DUT response with no expected entry (bus=%h raise=%b)", bus_data, raise);
        end else begin
          e   = sb_q.pop_front();
          act = e.is_irq ? {7'b0, raise} : bus_data;
          if (act !== e.exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", e.name, act, e.exp);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #1500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic read_reg(input logic [7:0] a, input logic [7:0] e, input string nm);
    @(negedge clk);
    sb_q.push_back('{nm, e, 1'b0});
    addr   = a;
    we     = 1'b0;
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    addr   = 8'h00;
  endtask

  task automatic write_reg(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk);
    addr   = a;
    wdata  = d;
    we     = 1'b1;
    tb_drv = 1'b1;
    @(negedge clk);
    we     = 1'b0;
    tb_drv = 1'b0;
    addr   = 8'h00;
  endtask

  task automatic check_irq(input logic e, input string nm);
    @(negedge clk);
    #1;
    sb_q.push_back('{nm, {7'b0, e}, 1'b1});
    irq_probe = 1'b1;
    @(negedge clk);
    #1;
    irq_probe = 1'b0;
  endtask

  task automatic pulse_ack();
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic burst(input int t);
    ir = 1'b1;
    repeat (t * TC) @(negedge clk);
    ir = 1'b0;
  endtask

  task automatic gap(input int t);
    repeat (t * TC) @(negedge clk);
  endtask

  task automatic send_frame(input logic [3:0] b, input int g);
    burst(240); gap(g);
    burst(60);  gap(g);
    for (int i = 3; i >= 0; i--) begin
      burst(b[i] ? 120 : 60);
      if (i != 0) gap(g);
    end
    gap(3);
  endtask

  initial begin : stimulus
    rst = 1'b1; ir = 1'b0; we = 1'b0; ack = 1'b0;
    addr = 8'h00; wdata = 8'h00; tb_drv = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;

    check_irq(1'b0, "rst_raise");
    read_reg(STAT, 8'h00, "rst_status");
    read_reg(BASE, 8'h00, "rst_data");

    // Frame 240/60/120/60/60/120 with 110-tick gaps; status probed mid last burst
    burst(240); gap(110);
    burst(60);  gap(110);
    burst(120); gap(110);
    burst(60);  gap(110);
    burst(60);  gap(110);
    ir = 1'b1;
    repeat (1100) @(negedge clk);
    read_reg(STAT, 8'h00, "valid_before_end");
    repeat (98) @(negedge clk);
    ir = 1'b0;
    gap(3);
    check_irq(1'b1, "f1_raise");
    read_reg(STAT, 8'h01, "f1_status");
    read_reg(BASE, 8'h09, "f1_data");
    read_reg(STAT, 8'h00, "f1_status_after_read");
    pulse_ack();
    check_irq(1'b0, "f1_ack");

    // Two frames without a read: overrun, newest byte kept
    send_frame(4'h5, 40);
    send_frame(4'hA, 40);
    read_reg(STAT, 8'h03, "ovr_status");
    check_irq(1'b1, "ovr_raise");
    read_reg(BASE, 8'h0A, "ovr_data");
    read_reg(STAT, 8'h02, "ovr_status_after_read");
    write_reg(STAT, 8'h02);
    read_reg(STAT, 8'h00, "ovr_w1c");
    write_reg(BASE, 8'hFF);
    read_reg(BASE, 8'h0A, "data_write_ignored");
    pulse_ack();
    check_irq(1'b0, "ovr_ack");

    // Gap timeout after SELECT
    burst(240); gap(40);
    burst(60);  gap(400);
    read_reg(STAT, 8'h04, "gap_timeout_err");
    check_irq(1'b0, "gap_timeout_noirq");
    write_reg(STAT, 8'h04);
    read_reg(STAT, 8'h00, "err_w1c");

    // Short bursts while idle are noise
    burst(20); gap(30);
    read_reg(STAT, 8'h00, "idle_glitch");
    burst(60); gap(30);
    read_reg(STAT, 8'h00, "idle_short");
    check_irq(1'b0, "idle_noirq");

    // START at data field 3 restarts the frame
    burst(240); gap(40);
    burst(60);  gap(40);
    burst(120); gap(40);
    send_frame(4'h6, 40);
    read_reg(STAT, 8'h01, "restart_status");
    check_irq(1'b1, "restart_raise");
    read_reg(BASE, 8'h06, "restart_data");

`ifdef IR_RX_GLITCH_FILTER_EN
    // 2-cycle spike inside a gap must vanish
    burst(240); gap(40);
    burst(60);
    repeat (200) @(negedge clk);
    ir = 1'b1;
    repeat (2) @(negedge clk);
    ir = 1'b0;
    repeat (198) @(negedge clk);
    burst(60);  gap(40);
    burst(60);  gap(40);
    burst(120); gap(40);
    burst(120); gap(3);
    read_reg(STAT, 8'h01, "filter_status");
    read_reg(BASE, 8'h03, "filter_data");
`endif

    // Reset mid-frame, then a clean frame
    burst(240); gap(40);
    burst(60);  gap(40);
    burst(120); gap(10);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_irq(1'b0, "midrst_raise");
    read_reg(STAT, 8'h00, "midrst_status");
    read_reg(BASE, 8'h00, "midrst_data");
    send_frame(4'hC, 40);
    check_irq(1'b1, "post_rst_raise");
    read_reg(STAT, 8'h01, "post_rst_status");
    read_reg(BASE, 8'h0C, "post_rst_data");

    repeat (4) @(negedge clk);
    if (sb_q.size() != 0) begin
      $display("FAIL sb_leftover: %0d expected responses never seen, required 0", sb_q.size());
      n_vec += sb_q.size();
      n_bad += sb_q.size();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
